// File: rtl/pit_multi_pkg.sv
// Shared definitions for the multi-channel interval timer: register map,
// CNTRL field layout and helpers to pack/unpack the control word.
package pit_multi_pkg;

    localparam logic [1:0] REG_CNTRL    = 2'd0;
    localparam logic [1:0] REG_MOD      = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_IRQ_PEND = 2'd3;

    localparam int unsigned BIT_ENA     = 0;
    localparam int unsigned BIT_IRQEN   = 1;
    localparam int unsigned BIT_FLAG    = 2;
    localparam int unsigned BIT_ONESHOT = 3;
    localparam int unsigned BIT_CHAIN   = 4;
    localparam int unsigned BIT_PS_LO   = 8;
    localparam int unsigned PS_FIELD_W  = 4;

    typedef struct packed {
        logic [PS_FIELD_W-1:0] ps;
        logic                  chain;
        logic                  oneshot;
        logic                  flag;
        logic                  irqen;
        logic                  ena;
    } cntrl_t;

    // Bus image of CNTRL; unassigned bits read as zero.
    function automatic logic [31:0] cntrl_to_word(input cntrl_t c);
        return {20'd0, c.ps, 3'd0, c.chain, c.oneshot, c.flag, c.irqen, c.ena};
    endfunction

    // Prescale exponents beyond the implemented prescaler saturate.
    function automatic logic [PS_FIELD_W-1:0] clamp_ps(input logic [PS_FIELD_W-1:0] ps,
                                                       input int unsigned max_ps);
        if (32'(ps) > max_ps) begin
            return PS_FIELD_W'(max_ps);
        end
        return ps;
    endfunction

endpackage

// File: rtl/pit_chan.sv
// One timer channel: prescaler, modulo counter, sticky FLAG and one-shot stop.
// o_roll_c is the unregistered rollover used to tick the next channel in a chain.
module pit_chan
    import pit_multi_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MAX_PS = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cntrl_we,
    input  cntrl_t           i_cntrl_wd,
    input  logic             i_mod_we,
    input  logic [CNT_W-1:0] i_mod_wd,
    input  logic             i_chain_tick,
    output logic             o_roll_c,
    output logic             o_pulse,
    output cntrl_t           o_cntrl,
    output logic [CNT_W-1:0] o_mod,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PS_W = (MAX_PS > 0) ? MAX_PS : 1;

    cntrl_t            r_cntrl;
    logic [CNT_W-1:0]  r_mod;
    logic [CNT_W-1:0]  r_count;
    logic [PS_W-1:0]   r_ps_cnt;
    logic              r_pulse;

    cntrl_t            w_cntrl_nxt;
    logic [PS_W-1:0]   w_ps_term;
    logic              w_ps_hit;
    logic              w_tick;
    logic [CNT_W-1:0]  w_limit;
    logic              w_roll;

    // >= rather than == so a PS decrease mid-run cannot strand the prescaler above its terminal
    assign w_ps_term = PS_W'((32'd1 << r_cntrl.ps) - 32'd1);
    assign w_ps_hit  = (r_ps_cnt >= w_ps_term);
    assign w_tick    = r_cntrl.chain ? i_chain_tick : w_ps_hit;
    assign w_limit   = (r_mod == '0) ? CNT_W'(1) : r_mod;
    assign w_roll    = r_cntrl.ena & w_tick & (r_count >= w_limit);

    // Bus write first, then rollover overrides: FLAG set beats clear, one-shot drops ENA.
    always_comb begin
        w_cntrl_nxt = r_cntrl;
        if (i_cntrl_we) begin
            w_cntrl_nxt.ena     = i_cntrl_wd.ena;
            w_cntrl_nxt.irqen   = i_cntrl_wd.irqen;
            w_cntrl_nxt.oneshot = i_cntrl_wd.oneshot;
            w_cntrl_nxt.chain   = i_cntrl_wd.chain;
            w_cntrl_nxt.ps      = clamp_ps(i_cntrl_wd.ps, MAX_PS);
            if (i_cntrl_wd.flag) begin
                w_cntrl_nxt.flag = 1'b0;
            end
        end
        if (w_roll) begin
            w_cntrl_nxt.flag = 1'b1;
            if (r_cntrl.oneshot) begin
                w_cntrl_nxt.ena = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cntrl  <= '0;
            r_mod    <= '0;
            r_count  <= CNT_W'(1);
            r_ps_cnt <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_cntrl <= w_cntrl_nxt;
            r_pulse <= w_roll;
            if (i_mod_we) begin
                r_mod <= i_mod_wd;
            end
            // Idle (or about to idle) channels park so re-enable starts a full period.
            if (!r_cntrl.ena || !w_cntrl_nxt.ena) begin
                r_count  <= CNT_W'(1);
                r_ps_cnt <= '0;
            end else begin
                if (w_tick) begin
                    r_count <= w_roll ? CNT_W'(1) : r_count + CNT_W'(1);
                end
                if (r_cntrl.chain || w_ps_hit) begin
                    r_ps_cnt <= '0;
                end else begin
                    r_ps_cnt <= r_ps_cnt + PS_W'(1);
                end
            end
        end
    end

    assign o_roll_c = w_roll;
    assign o_pulse  = r_pulse;
    assign o_cntrl  = r_cntrl;
    assign o_mod    = r_mod;
    assign o_count  = r_count;

endmodule

// File: rtl/pit_multi_top.sv
// Multi-channel programmable interval timer behind a WISHBONE classic slave:
// bus decode, registered ack/read data, IRQ aggregation and channel chaining.
module pit_multi_top
    import pit_multi_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_PS  = 15,
    parameter int unsigned A_WIDTH = 5
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [A_WIDTH-1:0] wb_adr,
    input  logic [CNT_W-1:0]   wb_dat_i,
    output logic [CNT_W-1:0]   wb_dat_o,
    input  logic               wb_we,
    input  logic               wb_stb,
    input  logic               wb_cyc,
    output logic               wb_ack,
    input  logic               ext_sync_i,
    output logic [N_CH-1:0]    pit_o,
    output logic [N_CH-1:0]    cnt_flag_o,
    output logic               pit_irq_o
);

    localparam int unsigned CH_AW = A_WIDTH - 2;

    logic              r_ack;
    logic [CNT_W-1:0]  r_dat_o;
    logic              r_irq;

    logic              w_req;
    logic              w_wr;
    logic [CH_AW-1:0]  w_ch;
    logic [1:0]        w_reg;
    logic [31:0]       w_wdat32;
    cntrl_t            w_cntrl_wd;
    logic [CNT_W-1:0]  w_rdata;
    logic              w_unused;

    logic [N_CH-1:0]   w_cntrl_we;
    logic [N_CH-1:0]   w_mod_we;
    logic [N_CH-1:0]   w_roll_c;
    logic [N_CH-1:0]   w_pulse;
    logic [N_CH-1:0]   w_flag;
    logic [N_CH-1:0]   w_irqen;
    logic [N_CH-1:0]   w_pend;
    cntrl_t            w_cntrl [N_CH];
    logic [CNT_W-1:0]  w_mod   [N_CH];
    logic [CNT_W-1:0]  w_count [N_CH];

    // A write lands on the ack edge only if the master still holds the strobe.
    assign w_req = wb_stb & wb_cyc & ~r_ack;
    assign w_wr  = r_ack & wb_stb & wb_cyc & wb_we;
    assign w_ch  = wb_adr[A_WIDTH-1:2];
    assign w_reg = wb_adr[1:0];

    assign w_wdat32           = 32'(wb_dat_i);
    assign w_cntrl_wd.ena     = w_wdat32[BIT_ENA];
    assign w_cntrl_wd.irqen   = w_wdat32[BIT_IRQEN];
    assign w_cntrl_wd.flag    = w_wdat32[BIT_FLAG];
    assign w_cntrl_wd.oneshot = w_wdat32[BIT_ONESHOT];
    assign w_cntrl_wd.chain   = w_wdat32[BIT_CHAIN];
    assign w_cntrl_wd.ps      = w_wdat32[BIT_PS_LO +: PS_FIELD_W];
    assign w_unused           = ^{w_wdat32[31:12], w_wdat32[7:5], w_roll_c[N_CH-1]};

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic w_chain_tick;

        if (gi == 0) begin : g_src
            assign w_chain_tick = ext_sync_i;
        end else begin : g_src
            assign w_chain_tick = w_roll_c[gi-1];
        end

        assign w_cntrl_we[gi] = w_wr & (w_reg == REG_CNTRL) & (w_ch == CH_AW'(gi));
        assign w_mod_we[gi]   = w_wr & (w_reg == REG_MOD)   & (w_ch == CH_AW'(gi));
        assign w_flag[gi]     = w_cntrl[gi].flag;
        assign w_irqen[gi]    = w_cntrl[gi].irqen;

        pit_chan #(
            .CNT_W  (CNT_W),
            .MAX_PS (MAX_PS)
        ) u_chan (
            .i_clk        (wb_clk),
            .i_rst        (wb_rst),
            .i_cntrl_we   (w_cntrl_we[gi]),
            .i_cntrl_wd   (w_cntrl_wd),
            .i_mod_we     (w_mod_we[gi]),
            .i_mod_wd     (wb_dat_i),
            .i_chain_tick (w_chain_tick),
            .o_roll_c     (w_roll_c[gi]),
            .o_pulse      (w_pulse[gi]),
            .o_cntrl      (w_cntrl[gi]),
            .o_mod        (w_mod[gi]),
            .o_count      (w_count[gi])
        );
    end

    assign w_pend = w_flag & w_irqen;

    // Read mux; channel indices past N_CH match nothing and read zero.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_ch == CH_AW'(k)) begin
                case (w_reg)
                    REG_CNTRL: w_rdata = CNT_W'(cntrl_to_word(w_cntrl[k]));
                    REG_MOD:   w_rdata = w_mod[k];
                    REG_COUNT: w_rdata = w_count[k];
                    default:   w_rdata = CNT_W'(w_pend);
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= w_req ? w_rdata : '0;
            r_irq   <= |w_pend;
        end
    end

    assign wb_ack     = r_ack;
    assign wb_dat_o   = r_dat_o;
    assign pit_o      = w_pulse;
    assign cnt_flag_o = w_flag;
    assign pit_irq_o  = r_irq;

endmodule

// File: tb/tb_pit_multi_top.sv
// Directed bench for pit_multi_top: register map, periodic/prescaled/one-shot
// timing, chaining, FLAG set-vs-clear collision and mid-transfer reset.
module tb_pit_multi_top;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned MAX_PS  = 15;
    localparam int unsigned A_WIDTH = 5;

    logic               wb_clk = 1'b0;
    logic               wb_rst = 1'b1;
    logic [A_WIDTH-1:0] wb_adr = '0;
    logic [CNT_W-1:0]   wb_dat_i = '0;
    logic [CNT_W-1:0]   wb_dat_o;
    logic               wb_we = 1'b0;
    logic               wb_stb = 1'b0;
    logic               wb_cyc = 1'b0;
    logic               wb_ack;
    logic               ext_sync_i = 1'b0;
    logic [N_CH-1:0]    pit_o;
    logic [N_CH-1:0]    cnt_flag_o;
    logic               pit_irq_o;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk = ~wb_clk;

    pit_multi_top #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .MAX_PS  (MAX_PS),
        .A_WIDTH (A_WIDTH)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .wb_adr     (wb_adr),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_we      (wb_we),
        .wb_stb     (wb_stb),
        .wb_cyc     (wb_cyc),
        .wb_ack     (wb_ack),
        .ext_sync_i (ext_sync_i),
        .pit_o      (pit_o),
        .cnt_flag_o (cnt_flag_o),
        .pit_irq_o  (pit_irq_o)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wb_clk);
            #1;
        end
    endtask

    // Entered just after an edge Ek; the write commits on Ek+2, return at Ek+2+1.
    task automatic bus_wr(input logic [2:0] ch, input logic [1:0] rg, input logic [15:0] d);
        wb_adr = {ch, rg}; wb_dat_i = d; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(posedge wb_clk); #1;
        checks++;
        if (wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack ch%0d reg%0d got %b exp 1", ch, rg, wb_ack);
        end
        @(posedge wb_clk); #1;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] ch, input logic [1:0] rg, output logic [15:0] d);
        wb_adr = {ch, rg}; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(posedge wb_clk); #1;
        d = wb_dat_o;
        checks++;
        if (wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL rd_ack ch%0d reg%0d got %b exp 1", ch, rg, wb_ack);
        end
        @(posedge wb_clk); #1;
        checks++;
        if (wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd_ack_width ch%0d reg%0d got %b exp 0", ch, rg, wb_ack);
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        logic [15:0] exp_v;
        step(3);
        wb_rst = 1'b0;
        checks++;
        if ({wb_ack, wb_dat_o, pit_o, cnt_flag_o, pit_irq_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b dat=%h pit=%b flag=%b irq=%b exp all 0",
                     wb_ack, wb_dat_o, pit_o, cnt_flag_o, pit_irq_o);
        end
        for (int ch = 0; ch < 4; ch++) begin
            for (int rg = 0; rg < 4; rg++) begin
                exp_v = (rg == 2) ? 16'h0001 : 16'h0000;
                bus_rd(3'(ch), 2'(rg), d);
                checks++;
                if (d !== exp_v) begin
                    errors++;
                    $display("FAIL reset_reg ch%0d reg%0d got %h exp %h", ch, rg, d, exp_v);
                end
            end
        end
        bus_wr(3'd0, 2'd2, 16'hFFFE);
        bus_rd(3'd0, 2'd2, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL count_ro got %h exp 0001", d);
        end
        bus_wr(3'd5, 2'd1, 16'h0077);
        bus_rd(3'd5, 2'd1, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL bad_ch_read got %h exp 0000", d);
        end
        bus_rd(3'd1, 2'd1, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL bad_ch_alias got %h exp 0000", d);
        end
    endtask

    task automatic test_periodic;
        logic [15:0] d;
        int np = 0;
        int p1 = -1;
        int p2 = -1;
        bus_wr(3'd0, 2'd1, 16'h0010);
        bus_wr(3'd0, 2'd0, 16'h0001);
        for (int n = 1; n <= 34; n++) begin
            step(1);
            if (pit_o[0]) begin
                np++;
                if (np == 1) p1 = n;
                if (np == 2) p2 = n;
            end
        end
        checks++;
        if (np !== 2 || p1 !== 16 || p2 !== 32) begin
            errors++;
            $display("FAIL periodic_pulses got n=%0d at %0d,%0d exp 2 at 16,32", np, p1, p2);
        end
        bus_rd(3'd0, 2'd0, d);
        checks++;
        if (d !== 16'h0005) begin
            errors++;
            $display("FAIL periodic_flag_set got %h exp 0005", d);
        end
        bus_wr(3'd0, 2'd0, 16'h0005);
        bus_rd(3'd0, 2'd0, d);
        checks++;
        if (d !== 16'h0001 || cnt_flag_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL periodic_w1c got %h flag=%b exp 0001 flag=0", d, cnt_flag_o[0]);
        end
        bus_wr(3'd0, 2'd0, 16'h0000);
    endtask

    task automatic test_prescale_irq;
        logic [15:0] d;
        int np = 0;
        int p1 = -1;
        int p2 = -1;
        bus_wr(3'd1, 2'd1, 16'h0004);
        bus_wr(3'd1, 2'd0, 16'h0203);
        for (int n = 1; n <= 34; n++) begin
            step(1);
            if (pit_o[1]) begin
                np++;
                if (np == 1) p1 = n;
                if (np == 2) p2 = n;
            end
        end
        checks++;
        if (np !== 2 || p1 !== 16 || p2 !== 32) begin
            errors++;
            $display("FAIL prescale_pulses got n=%0d at %0d,%0d exp 2 at 16,32", np, p1, p2);
        end
        checks++;
        if (pit_irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b exp 1", pit_irq_o);
        end
        bus_rd(3'd3, 2'd3, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("FAIL irq_pend_ch3 got %h exp 0002", d);
        end
        bus_rd(3'd0, 2'd3, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("FAIL irq_pend_ch0 got %h exp 0002", d);
        end
        bus_wr(3'd1, 2'd0, 16'h0004);
        step(2);
        checks++;
        if (pit_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b exp 0", pit_irq_o);
        end
        bus_rd(3'd1, 2'd3, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL irq_pend_clear got %h exp 0000", d);
        end
    endtask

    task automatic test_oneshot;
        logic [15:0] d;
        int np = 0;
        int p1 = -1;
        bus_wr(3'd2, 2'd1, 16'h0005);
        bus_wr(3'd2, 2'd0, 16'h0009);
        for (int n = 1; n <= 30; n++) begin
            step(1);
            if (pit_o[2]) begin
                np++;
                if (np == 1) p1 = n;
            end
        end
        checks++;
        if (np !== 1 || p1 !== 5) begin
            errors++;
            $display("FAIL oneshot_pulses got n=%0d first=%0d exp 1 at 5", np, p1);
        end
        bus_rd(3'd2, 2'd0, d);
        checks++;
        if (d !== 16'h000C) begin
            errors++;
            $display("FAIL oneshot_cntrl got %h exp 000c", d);
        end
        bus_rd(3'd2, 2'd2, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL oneshot_count got %h exp 0001", d);
        end
        bus_wr(3'd2, 2'd0, 16'h0004);
    endtask

    task automatic test_chain;
        int c0 = 0;
        int nq = 0;
        int q1 = -1;
        int q2 = -1;
        int both = 0;
        bus_wr(3'd1, 2'd0, 16'h0011);
        bus_wr(3'd0, 2'd1, 16'h0003);
        bus_wr(3'd0, 2'd0, 16'h0001);
        for (int n = 1; n <= 26; n++) begin
            step(1);
            if (pit_o[0]) c0++;
            if (pit_o[1]) begin
                nq++;
                if (nq == 1) q1 = n;
                if (nq == 2) q2 = n;
                if (pit_o[0]) both++;
            end
        end
        checks++;
        if (c0 !== 8 || nq !== 2 || q1 !== 12 || q2 !== 24 || both !== 2) begin
            errors++;
            $display("FAIL chain got c0=%0d c1=%0d at %0d,%0d coincident=%0d exp 8,2 at 12,24 coincident=2",
                     c0, nq, q1, q2, both);
        end
        bus_wr(3'd0, 2'd0, 16'h0004);
        bus_wr(3'd1, 2'd0, 16'h0004);
        // ch0 chained to the external tick, MOD=2: two sync cycles give one rollover
        bus_wr(3'd0, 2'd1, 16'h0002);
        bus_wr(3'd0, 2'd0, 16'h0011);
        ext_sync_i = 1'b1;
        step(2);
        ext_sync_i = 1'b0;
        checks++;
        if (pit_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL ext_sync_pulse got %b exp 1", pit_o[0]);
        end
        step(1);
        checks++;
        if (pit_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL ext_sync_pulse_width got %b exp 0", pit_o[0]);
        end
        bus_wr(3'd0, 2'd0, 16'h0004);
    endtask

    task automatic test_collision_and_reset;
        logic [15:0] d;
        bus_wr(3'd3, 2'd1, 16'h0008);
        bus_wr(3'd3, 2'd0, 16'h0001);
        step(14);
        bus_wr(3'd3, 2'd0, 16'h0005);
        checks++;
        if (pit_o[3] !== 1'b1 || cnt_flag_o[3] !== 1'b1) begin
            errors++;
            $display("FAIL flag_collision pit=%b flag=%b exp 1 1", pit_o[3], cnt_flag_o[3]);
        end
        bus_rd(3'd3, 2'd0, d);
        checks++;
        if (d !== 16'h0005) begin
            errors++;
            $display("FAIL flag_collision_read got %h exp 0005", d);
        end
        step(3);
        wb_adr = {3'd3, 2'd1}; wb_dat_i = 16'h0055; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(posedge wb_clk); #1;
        checks++;
        if (wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL rst_xfer_ack got %b exp 1", wb_ack);
        end
        wb_rst = 1'b1;
        @(posedge wb_clk); #1;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_rst = 1'b0;
        checks++;
        if ({wb_ack, wb_dat_o, pit_o, cnt_flag_o, pit_irq_o} !== '0) begin
            errors++;
            $display("FAIL rst_outputs got ack=%b dat=%h pit=%b flag=%b irq=%b exp all 0",
                     wb_ack, wb_dat_o, pit_o, cnt_flag_o, pit_irq_o);
        end
        bus_rd(3'd3, 2'd1, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL rst_write_lost got %h exp 0000", d);
        end
        bus_rd(3'd3, 2'd2, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL rst_count got %h exp 0001", d);
        end
        bus_rd(3'd3, 2'd0, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL rst_cntrl got %h exp 0000", d);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_prescale_irq();
        test_oneshot();
        test_chain();
        test_collision_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
